// File: rtl/support_seq.sv
// Front-panel and reset sequencer: debounces the board buttons and walks the
// DCM reset -> lock wait -> CPU reset -> boot sequence ahead of the core.
module support_seq #(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int DCM_RESET_CYCLES = 4,
    parameter int CPU_RESET_CYCLES = 64,
    parameter int BOOT_CYCLES      = 8,
    parameter int CNT_W            = 20
) (
    input  logic sysclk,
    input  logic reset,
    input  logic button_r,
    input  logic button_b,
    input  logic button_h,
    input  logic button_c,
    input  logic dcm_locked,
    output logic dcm_reset,
    output logic cpu_reset,
    output logic interrupt,
    output logic boot,
    output logic halt
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCM_LAST  = CNT_W'(DCM_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_DCM,
        S_LOCK,
        S_RESET,
        S_BOOT,
        S_RUN
    } state_t;

    // Button bit order: [0]=r, [1]=b, [2]=h, [3]=c
    logic [3:0]       btn_raw;
    logic [3:0]       bsync1_q, bsync2_q;
    logic [3:0]       deb_q, deb_d;
    logic [3:0]       press_q, press_d;
    logic [CNT_W-1:0] dcnt_q [4];
    logic [CNT_W-1:0] dcnt_d [4];
    logic             lsync1_q, lsync2_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             boot_req_q, boot_req_d;
    logic             halt_q, halt_d;
    logic             int_q, int_d;
    logic             dcm_reset_q, dcm_reset_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             boot_q, boot_d;
    logic             lock_lost;

    assign btn_raw = {button_c, button_h, button_b, button_r};

    always_comb begin
        deb_d   = deb_q;
        press_d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            dcnt_d[i] = '0;
            if (bsync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    deb_d[i]   = ~deb_q[i];
                    press_d[i] = ~deb_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            bsync1_q <= '0;
            bsync2_q <= '0;
            deb_q    <= '0;
            press_q  <= '0;
            lsync1_q <= 1'b0;
            lsync2_q <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            bsync1_q <= btn_raw;
            bsync2_q <= bsync1_q;
            deb_q    <= deb_d;
            press_q  <= press_d;
            lsync1_q <= dcm_locked;
            lsync2_q <= lsync1_q;
            for (int unsigned i = 0; i < 4; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    assign lock_lost = !lsync2_q &&
                       (state_q == S_RESET || state_q == S_BOOT || state_q == S_RUN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        boot_req_d = boot_req_q;
        halt_d     = halt_q;
        int_d      = 1'b0;

        case (state_q)
            S_DCM: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DCM_LAST) state_d = S_LOCK;
            end
            S_LOCK: begin
                if (lsync2_q) state_d = S_RESET;
            end
            S_RESET: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CPU_LAST) state_d = boot_req_q ? S_BOOT : S_RUN;
            end
            S_BOOT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BOOT_LAST) begin
                    boot_req_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                // A reset request swallows any halt/interrupt press in the same cycle
                if (press_q[1]) begin
                    boot_req_d = 1'b1;
                    state_d    = S_RESET;
                end else if (press_q[0]) begin
                    boot_req_d = 1'b0;
                    state_d    = S_RESET;
                end else begin
                    if (press_q[2]) halt_d = ~halt_q;
                    int_d = press_q[3];
                end
            end
            default: state_d = S_DCM;
        endcase

        if (lock_lost) begin
            state_d    = S_LOCK;
            boot_req_d = 1'b1;
            halt_d     = halt_q;
            int_d      = 1'b0;
        end

        if (state_d != state_q) cnt_d = '0;
        if (state_d == S_RESET && state_q != S_RESET) halt_d = 1'b0;

        dcm_reset_d = (state_d == S_DCM);
        cpu_reset_d = (state_d == S_DCM) || (state_d == S_LOCK) || (state_d == S_RESET);
        boot_d      = (state_d == S_BOOT);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= S_DCM;
            cnt_q       <= '0;
            boot_req_q  <= 1'b1;
            halt_q      <= 1'b0;
            int_q       <= 1'b0;
            dcm_reset_q <= 1'b1;
            cpu_reset_q <= 1'b1;
            boot_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            boot_req_q  <= boot_req_d;
            halt_q      <= halt_d;
            int_q       <= int_d;
            dcm_reset_q <= dcm_reset_d;
            cpu_reset_q <= cpu_reset_d;
            boot_q      <= boot_d;
        end
    end

    assign dcm_reset = dcm_reset_q;
    assign cpu_reset = cpu_reset_q;
    assign interrupt = int_q;
    assign boot      = boot_q;
    assign halt      = halt_q;

endmodule

// File: tb/tb_support_seq.sv
// Scoreboard bench for support_seq: each stimulus step queues the output
// transitions it should cause; a negedge monitor pops and compares them.
module tb_support_seq;

    logic sysclk = 1'b0;
    logic reset;
    logic button_r, button_b, button_h, button_c;
    logic dcm_locked;
    logic dcm_reset, cpu_reset, interrupt, boot, halt;

    int unsigned cyc = 0;
    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    bit          mon_en = 1'b0;
    logic [4:0]  mon_prev;
    logic [4:0]  mon_cur;
    logic [31:0] mon_got;
    logic [31:0] mon_exp;

    // Output signal ids used in event records
    localparam int unsigned SIG_DCM  = 0;
    localparam int unsigned SIG_CPU  = 1;
    localparam int unsigned SIG_INT  = 2;
    localparam int unsigned SIG_BOOT = 3;
    localparam int unsigned SIG_HALT = 4;

    support_seq #(
        .DEBOUNCE_CYCLES (4),
        .DCM_RESET_CYCLES(4),
        .CPU_RESET_CYCLES(8),
        .BOOT_CYCLES     (3),
        .CNT_W           (20)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .button_r  (button_r),
        .button_b  (button_b),
        .button_h  (button_h),
        .button_c  (button_c),
        .dcm_locked(dcm_locked),
        .dcm_reset (dcm_reset),
        .cpu_reset (cpu_reset),
        .interrupt (interrupt),
        .boot      (boot),
        .halt      (halt)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    // Event record: {cycle, signal id, new value}
    function automatic logic [31:0] ev(input int unsigned c, input int unsigned s, input bit v);
        return {c[27:0], s[2:0], v};
    endfunction

    task automatic expect_ev(input int unsigned c, input int unsigned s, input bit v);
        exp_q.push_back(ev(c, s, v));
    endtask

    always @(negedge sysclk) begin
        if (mon_en) begin
            mon_cur = {halt, boot, interrupt, cpu_reset, dcm_reset};
            for (int s = 0; s < 5; s++) begin
                if (mon_cur[s] !== mon_prev[s]) begin
                    mon_got = ev(cyc, s, mon_cur[s]);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", mon_got, 32'h0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("event", mon_got, mon_exp);
                    end
                end
            end
            mon_prev = mon_cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    // mask bits: [0]=r, [1]=b, [2]=h, [3]=c
    task automatic hold_release(input logic [3:0] m);
        {button_c, button_h, button_b, button_r} = m;
        tick(10);
        {button_c, button_h, button_b, button_r} = 4'b0000;
        tick(10);
    endtask

    task automatic expect_power_on(input int unsigned r);
        expect_ev(r + 4,  SIG_DCM,  1'b0);
        expect_ev(r + 13, SIG_CPU,  1'b0);
        expect_ev(r + 13, SIG_BOOT, 1'b1);
        expect_ev(r + 16, SIG_BOOT, 1'b0);
    endtask

    task automatic check_drained(input string tag);
        chk(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c, d, r;
        reset = 1'b1;
        {button_c, button_h, button_b, button_r} = 4'b0000;
        dcm_locked = 1'b1;

        // Power-on
        tick(2);
        r = cyc;
        reset = 1'b0;
        chk("rst_dcm_reset", 32'(dcm_reset), 32'd1);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_boot",      32'(boot),      32'd0);
        chk("rst_halt",      32'(halt),      32'd0);
        mon_prev = 5'b00011;
        mon_en   = 1'b1;
        expect_power_on(r);
        tick(22);
        check_drained("power_on_pending");

        // Bounce rejection: toggling every 2 cycles never settles
        for (int i = 0; i < 10; i++) begin
            button_c = ~button_c;
            tick(2);
        end
        tick(10);
        check_drained("bounce_pending");

        // Clean interrupt press
        c = cyc;
        expect_ev(c + 7, SIG_INT, 1'b1);
        expect_ev(c + 8, SIG_INT, 1'b0);
        hold_release(4'b1000);
        check_drained("interrupt_pending");

        // Halt toggles on, then off
        c = cyc;
        expect_ev(c + 7, SIG_HALT, 1'b1);
        hold_release(4'b0100);
        c = cyc;
        expect_ev(c + 7, SIG_HALT, 1'b0);
        hold_release(4'b0100);
        check_drained("halt_toggle_pending");

        // Halt on, then button_r clears it and resets without boot
        c = cyc;
        expect_ev(c + 7, SIG_HALT, 1'b1);
        hold_release(4'b0100);
        c = cyc;
        expect_ev(c + 7,  SIG_CPU,  1'b1);
        expect_ev(c + 7,  SIG_HALT, 1'b0);
        expect_ev(c + 15, SIG_CPU,  1'b0);
        hold_release(4'b0001);
        tick(5);
        check_drained("halt_clear_pending");

        // r and b together: b wins, boot follows reset
        c = cyc;
        expect_ev(c + 7,  SIG_CPU,  1'b1);
        expect_ev(c + 15, SIG_CPU,  1'b0);
        expect_ev(c + 15, SIG_BOOT, 1'b1);
        expect_ev(c + 18, SIG_BOOT, 1'b0);
        hold_release(4'b0011);
        tick(5);
        check_drained("simul_pending");

        // Lock lost while booting, then restored
        c = cyc;
        expect_ev(c + 7,  SIG_CPU,  1'b1);
        expect_ev(c + 15, SIG_CPU,  1'b0);
        expect_ev(c + 15, SIG_BOOT, 1'b1);
        expect_ev(c + 18, SIG_CPU,  1'b1);
        expect_ev(c + 18, SIG_BOOT, 1'b0);
        button_b = 1'b1;
        tick(10);
        button_b = 1'b0;
        tick(5);
        dcm_locked = 1'b0;
        tick(5);
        chk("lock_loss_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("lock_loss_boot",      32'(boot),      32'd0);
        d = cyc;
        dcm_locked = 1'b1;
        expect_ev(d + 11, SIG_CPU,  1'b0);
        expect_ev(d + 11, SIG_BOOT, 1'b1);
        expect_ev(d + 14, SIG_BOOT, 1'b0);
        tick(20);
        check_drained("lock_restore_pending");

        // Reset asserted in the sixth S_RESET cycle restarts the full sequence
        c = cyc;
        expect_ev(c + 7, SIG_CPU, 1'b1);
        button_r = 1'b1;
        tick(10);
        button_r = 1'b0;
        tick(2);
        reset = 1'b1;
        expect_ev(c + 13, SIG_DCM, 1'b1);
        tick(1);
        chk("mid_reset_dcm_reset", 32'(dcm_reset), 32'd1);
        chk("mid_reset_cpu_reset", 32'(cpu_reset), 32'd1);
        r = cyc;
        reset = 1'b0;
        expect_power_on(r);
        tick(25);
        check_drained("mid_reset_pending");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
